// File: rtl/pb_io_responder.sv
// ---------------------------------------------------------------------------
// pb_io_responder
//
// Peripheral-side responder for the KCPSM6 (PicoBlaze) I/O port bus. Decodes
// CPU accesses whose port_id upper nibble equals PORT_BASE and provides:
//   - four write-only output registers (offsets 0x0-0x3)
//   - interrupt pending (0x4, W1C) and mask (0x5) registers
//   - an 8-source rising-edge interrupt controller with IDLE/REQ/WAIT handshake
//   - a byte FIFO fed by an external producer, popped by reads of 0x6,
//     with status at 0x7 = {count[4:0], ovf, full, empty}
//   - four readable input ports (offsets 0x8-0xB)
//
// Ports:
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   port_id, read_strobe,
//   write_strobe, out_port: CPU access bus
//   in_port               : registered read data (1-cycle latency from port_id)
//   interrupt, interrupt_ack : interrupt request / acknowledge
//   out_reg0..3           : output registers
//   in_val0..3            : input ports
//   evt                   : interrupt sources, rising-edge sensitive
//   fifo_wr_en, fifo_wr_data, fifo_full : FIFO producer interface
//
// Optional build macro: PB_IO_IN_SYNC_EN
//   Defined   : in_val0..3 and evt pass through a 2-flop synchronizer.
//   Undefined : inputs are used directly.
// ---------------------------------------------------------------------------
module pb_io_responder #(
    parameter logic [3:0]  PORT_BASE = 4'h0,
    parameter int unsigned FIFO_AW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       write_strobe,
    input  logic [7:0] out_port,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [7:0] out_reg0,
    output logic [7:0] out_reg1,
    output logic [7:0] out_reg2,
    output logic [7:0] out_reg3,
    input  logic [7:0] in_val0,
    input  logic [7:0] in_val1,
    input  logic [7:0] in_val2,
    input  logic [7:0] in_val3,
    input  logic [7:0] evt,
    input  logic       fifo_wr_en,
    input  logic [7:0] fifo_wr_data,
    output logic       fifo_full
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] COUNT_FULL = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} irq_state_e;

    // ---------------- input conditioning ----------------
    logic [7:0] in_val_s [4];
    logic [7:0] evt_s;

`ifdef PB_IO_IN_SYNC_EN
    logic [39:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {evt, in_val3, in_val2, in_val1, in_val0};
            sync2_q <= sync1_q;
        end
    end

    assign in_val_s[0] = sync2_q[7:0];
    assign in_val_s[1] = sync2_q[15:8];
    assign in_val_s[2] = sync2_q[23:16];
    assign in_val_s[3] = sync2_q[31:24];
    assign evt_s       = sync2_q[39:32];
`else
    assign in_val_s[0] = in_val0;
    assign in_val_s[1] = in_val1;
    assign in_val_s[2] = in_val2;
    assign in_val_s[3] = in_val3;
    assign evt_s       = evt;
`endif

    // ---------------- state ----------------
    logic [7:0]         out_reg_q [4], out_reg_d [4];
    logic [7:0]         in_port_q, in_port_d;
    logic [7:0]         pend_q, pend_d;
    logic [7:0]         mask_q, mask_d;
    logic [7:0]         evt_hist_q, evt_hist_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    irq_state_e         state_q, state_d;
    logic [7:0]         mem_q [DEPTH];

    // ---------------- decode ----------------
    logic       hit, wr_hit, pop_ok, push_ok, fifo_empty, full_w;
    logic [3:0] offs;
    logic [7:0] w1c;
    logic [4:0] count5;

    assign hit        = (port_id[7:4] == PORT_BASE);
    assign offs       = port_id[3:0];
    assign wr_hit     = write_strobe & hit;
    assign fifo_empty = (count_q == '0);
    assign full_w     = (count_q == COUNT_FULL);
    assign count5     = 5'(count_q);
    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign pop_ok     = read_strobe & hit & (offs == 4'h6) & ~fifo_empty;
    assign push_ok    = fifo_wr_en & (~full_w | pop_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        out_reg_d  = out_reg_q;
        mask_d     = mask_q;
        ovf_d      = ovf_q;
        w1c        = 8'h00;
        evt_hist_d = evt_s;
        if (wr_hit) begin
            case (offs)
                4'h0, 4'h1, 4'h2, 4'h3: out_reg_d[offs[1:0]] = out_port;
                4'h4:    w1c    = out_port;
                4'h5:    mask_d = out_port;
                4'h7:    ovf_d  = 1'b0;
                default: ;
            endcase
        end
        // A dropped byte wins over a same-cycle ovf clear.
        if (fifo_wr_en && full_w && !pop_ok) ovf_d = 1'b1;
        // Newly captured edges take priority over the W1C clear.
        pend_d = (pend_q & ~w1c) | (evt_s & ~evt_hist_q);
    end

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
    end

    // Read mux, registered every cycle regardless of read_strobe
    always_comb begin
        in_port_d = 8'h00;
        if (hit) begin
            case (offs)
                4'h4:    in_port_d = pend_q;
                4'h5:    in_port_d = mask_q;
                4'h6:    in_port_d = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
                4'h7:    in_port_d = {count5, ovf_q, full_w, fifo_empty};
                4'h8:    in_port_d = in_val_s[0];
                4'h9:    in_port_d = in_val_s[1];
                4'hA:    in_port_d = in_val_s[2];
                4'hB:    in_port_d = in_val_s[3];
                default: in_port_d = 8'h00;
            endcase
        end
    end

    // Interrupt handshake: REQ holds until acknowledged; WAIT holds until
    // software clears (or masks) every enabled pending bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if ((pend_q & mask_q) != 8'h00) state_d = ST_REQ;
            ST_REQ:  if (interrupt_ack)              state_d = ST_WAIT;
            ST_WAIT: if ((pend_q & mask_q) == 8'h00) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) out_reg_q[i] <= 8'h00;
            in_port_q  <= 8'h00;
            pend_q     <= 8'h00;
            mask_q     <= 8'h00;
            evt_hist_q <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            out_reg_q  <= out_reg_d;
            in_port_q  <= in_port_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            evt_hist_q <= evt_hist_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
        end
    end

    // NOTE: FIFO storage has no reset; cleared pointers make its contents unreachable.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= fifo_wr_data;
    end

    assign in_port   = in_port_q;
    assign interrupt = (state_q == ST_REQ);
    assign fifo_full = full_w;
    assign out_reg0  = out_reg_q[0];
    assign out_reg1  = out_reg_q[1];
    assign out_reg2  = out_reg_q[2];
    assign out_reg3  = out_reg_q[3];

endmodule

// File: tb/tb_pb_io_responder.sv
// ---------------------------------------------------------------------------
// tb_pb_io_responder
//
// Self-checking bench for pb_io_responder (default build, PORT_BASE=0,
// FIFO_AW=4). Inputs are driven on the falling edge; read data is sampled
// 1 time unit after the rising edge. Read expectations go through a small
// scoreboard queue. Register access uses a table of vectors; FIFO and
// interrupt corner cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_pb_io_responder;

    logic       clk, reset;
    logic [7:0] port_id, out_port, in_port;
    logic       read_strobe, write_strobe;
    logic       interrupt, interrupt_ack;
    logic [7:0] out_reg0, out_reg1, out_reg2, out_reg3;
    logic [7:0] in_val0, in_val1, in_val2, in_val3;
    logic [7:0] evt, fifo_wr_data;
    logic       fifo_wr_en, fifo_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q [$];
    string      name_q [$];

    typedef enum logic {OP_WR, OP_RD} op_e;
    typedef struct {
        op_e        op;
        logic [7:0] addr;
        logic [7:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [16];

    pb_io_responder #(.PORT_BASE(4'h0), .FIFO_AW(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .write_strobe (write_strobe),
        .out_port     (out_port),
        .in_port      (in_port),
        .interrupt    (interrupt),
        .interrupt_ack(interrupt_ack),
        .out_reg0     (out_reg0),
        .out_reg1     (out_reg1),
        .out_reg2     (out_reg2),
        .out_reg3     (out_reg3),
        .in_val0      (in_val0),
        .in_val1      (in_val1),
        .in_val2      (in_val2),
        .in_val3      (in_val3),
        .evt          (evt),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%02h required=%02h", nm, act, exp);
        end
    endtask

    task automatic sb_compare();
        logic [7:0] e;
        string      nm;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: read sampled with no expectation queued");
        end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check(nm, in_port, e);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic cpu_read(input logic [7:0] a, input logic [7:0] e, input string nm);
        port_id     = a;
        read_strobe = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
        fifo_wr_en  = 1'b0;
        port_id     = 8'hF0;
        sb_compare();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        port_id      = a;
        out_port     = d;
        write_strobe = 1'b1;
        @(posedge clk);
        #1;
        write_strobe = 1'b0;
        port_id      = 8'hF0;
        @(negedge clk);
    endtask

    task automatic fifo_push(input logic [7:0] d);
        fifo_wr_data = d;
        fifo_wr_en   = 1'b1;
        @(posedge clk);
        #1;
        fifo_wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; port_id = 8'hF0; out_port = 8'h00;
        read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0;
        in_val0 = 8'h11; in_val1 = 8'h22; in_val2 = 8'h33; in_val3 = 8'h44;
        evt = 8'h00; fifo_wr_en = 1'b0; fifo_wr_data = 8'h00;

        vecs[0]  = '{OP_WR, 8'h02, 8'hA5};
        vecs[1]  = '{OP_WR, 8'h05, 8'h3C};
        vecs[2]  = '{OP_RD, 8'h05, 8'h3C};
        vecs[3]  = '{OP_WR, 8'h12, 8'hFF};   // base miss
        vecs[4]  = '{OP_RD, 8'h05, 8'h3C};
        vecs[5]  = '{OP_RD, 8'h02, 8'h00};   // write-only
        vecs[6]  = '{OP_WR, 8'h00, 8'h5A};
        vecs[7]  = '{OP_WR, 8'h03, 8'hC3};
        vecs[8]  = '{OP_RD, 8'h08, 8'h11};
        vecs[9]  = '{OP_RD, 8'h09, 8'h22};
        vecs[10] = '{OP_RD, 8'h0A, 8'h33};
        vecs[11] = '{OP_RD, 8'h0B, 8'h44};
        vecs[12] = '{OP_RD, 8'h0C, 8'h00};   // unmapped
        vecs[13] = '{OP_RD, 8'h15, 8'h00};   // base miss
        vecs[14] = '{OP_RD, 8'h04, 8'h00};
        vecs[15] = '{OP_RD, 8'h07, 8'h01};

        // ---------------- reset ----------------
        #3 reset = 1'b0;
        idle_cycles(3);
        reset = 1'b1;
        check("rst_in_port",   in_port,   8'h00);
        check("rst_interrupt", 8'(interrupt), 8'h00);
        check("rst_out_reg0",  out_reg0,  8'h00);
        check("rst_out_reg1",  out_reg1,  8'h00);
        check("rst_out_reg2",  out_reg2,  8'h00);
        check("rst_out_reg3",  out_reg3,  8'h00);
        check("rst_fifo_full", 8'(fifo_full), 8'h00);
        cpu_read(8'h07, 8'h01, "rst_stat");

        // ---------------- register access ----------------
        cpu_write(8'h01, 8'h77);
        check("out_reg1_next_cycle", out_reg1, 8'h77);
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].op == OP_WR) cpu_write(vecs[i].addr, vecs[i].data);
            else cpu_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d_rd_%02h", i, vecs[i].addr));
        end
        check("out_reg0", out_reg0, 8'h5A);
        check("out_reg1", out_reg1, 8'h77);
        check("out_reg2", out_reg2, 8'hA5);
        check("out_reg3", out_reg3, 8'hC3);

        // ---------------- FIFO fill / overflow / drain ----------------
        for (int i = 0; i < 17; i++) begin
            fifo_push(8'(i));
            if (i == 14) check("fifo_full_after15", 8'(fifo_full), 8'h00);
            if (i == 15) check("fifo_full_after16", 8'(fifo_full), 8'h01);
        end
        cpu_read(8'h07, 8'h86, "stat_full_ovf");
        for (int i = 0; i < 16; i++) begin
            cpu_read(8'h06, 8'(i), $sformatf("fifo_pop%0d", i));
            if (i == 0) check("fifo_full_after_pop", 8'(fifo_full), 8'h00);
        end
        cpu_read(8'h07, 8'h05, "stat_empty_ovf");
        cpu_read(8'h06, 8'h00, "fifo_pop_empty");
        cpu_read(8'h07, 8'h05, "stat_after_empty_pop");
        cpu_write(8'h07, 8'h00);
        cpu_read(8'h07, 8'h01, "stat_ovf_cleared");

        // ---------------- simultaneous push/pop at full ----------------
        for (int i = 0; i < 16; i++) fifo_push(8'h20 + 8'(i));
        check("fifo_full_refill", 8'(fifo_full), 8'h01);
        fifo_wr_data = 8'h30;
        fifo_wr_en   = 1'b1;
        cpu_read(8'h06, 8'h20, "pushpop_head");
        cpu_read(8'h07, 8'h82, "stat_pushpop_no_ovf");
        for (int i = 1; i < 17; i++)
            cpu_read(8'h06, 8'h20 + 8'(i), $sformatf("pushpop_drain%0d", i));
        cpu_read(8'h07, 8'h01, "stat_pushpop_empty");

        // ---------------- interrupt handshake ----------------
        cpu_write(8'h05, 8'h01);
        evt = 8'h01;
        @(negedge clk);                       // pending captured
        check("irq_not_yet", 8'(interrupt), 8'h00);
        @(negedge clk);                       // IDLE -> REQ
        check("irq_raised", 8'(interrupt), 8'h01);
        evt = 8'h00;
        interrupt_ack = 1'b1;
        @(posedge clk);
        #1 interrupt_ack = 1'b0;
        @(negedge clk);
        check("irq_acked", 8'(interrupt), 8'h00);
        // second edge while waiting: no new request
        evt = 8'h01;
        @(negedge clk);
        evt = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("irq_wait_quiet%0d", i), 8'(interrupt), 8'h00);
        end
        cpu_read(8'h04, 8'h01, "pend_in_wait");
        // edge coincident with W1C: the set wins, pending stays
        evt = 8'h01;
        cpu_write(8'h04, 8'h01);
        evt = 8'h00;
        cpu_read(8'h04, 8'h01, "pend_set_priority");
        check("irq_still_wait", 8'(interrupt), 8'h00);
        // clear with no edge: back to IDLE, no request
        cpu_write(8'h04, 8'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("irq_cleared_quiet%0d", i), 8'(interrupt), 8'h00);
        end
        cpu_read(8'h04, 8'h00, "pend_cleared");
        // pending re-set from IDLE re-requests
        evt = 8'h01;
        @(negedge clk);
        evt = 8'h00;
        @(negedge clk);
        check("irq_rerequest", 8'(interrupt), 8'h01);
        cpu_write(8'h05, 8'h00);              // mask write during REQ
        check("irq_mask_in_req", 8'(interrupt), 8'h01);
        interrupt_ack = 1'b1;
        @(posedge clk);
        #1 interrupt_ack = 1'b0;
        @(negedge clk);
        check("irq_acked2", 8'(interrupt), 8'h00);
        cpu_write(8'h04, 8'h01);
        idle_cycles(2);
        check("irq_final_quiet", 8'(interrupt), 8'h00);
        cpu_read(8'h04, 8'h00, "pend_final");

        // ---------------- masked event ----------------
        evt = 8'h08;
        idle_cycles(2);
        evt = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("irq_masked_quiet%0d", i), 8'(interrupt), 8'h00);
        end
        cpu_read(8'h04, 8'h08, "pend_masked");
        begin
            logic got;
            got = 1'b0;
            port_id      = 8'h05;
            out_port     = 8'h08;
            write_strobe = 1'b1;
            for (int i = 0; i < 2 && !got; i++) begin
                @(posedge clk);
                #1 write_strobe = 1'b0;
                port_id = 8'hF0;
                @(negedge clk);
                if (interrupt) got = 1'b1;
            end
            check("irq_unmasked_within2", 8'(got), 8'h01);
        end

        // ---------------- reset mid-interrupt with FIFO data ----------------
        fifo_push(8'hAA);
        fifo_push(8'hBB);
        check("irq_before_reset", 8'(interrupt), 8'h01);
        reset = 1'b0;
        #1;
        check("midrst_interrupt", 8'(interrupt), 8'h00);
        check("midrst_out_reg0",  out_reg0, 8'h00);
        check("midrst_out_reg2",  out_reg2, 8'h00);
        check("midrst_in_port",   in_port,  8'h00);
        @(negedge clk);
        reset = 1'b1;
        cpu_read(8'h07, 8'h01, "midrst_stat");
        cpu_read(8'h04, 8'h00, "midrst_pend");
        cpu_read(8'h05, 8'h00, "midrst_mask");
        idle_cycles(2);
        check("midrst_irq_quiet", 8'(interrupt), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
